pu_riscv_bru: RTL and testbench
===============================

PU_RISCV_BRU -- requirements
Module: pu_riscv_bru

Interface
REQ-001 Parameters SHALL be: XLEN 64 (datapath width); ILEN 64 (instruction width); PC_INIT 'h8000_0000 (reset next-PC); BP_GLOBAL_BITS 2 (global history bits); HAS_RVC 1 (16-bit instructions supported); RAS_DEPTH 8 (return-address-stack entries, power of 2, >=2).
REQ-002 Ports, in order (name, direction, width, meaning):
- clk  in  1  the only clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- ex_stall  in  1  hold all state and outputs.
- st_flush  in  1  pipeline flush; squash current instruction.
- id_bubble  in  1  current slot invalid.
- id_pc  in  XLEN  PC of current instruction.
- id_instr  in  ILEN  instruction.
- id_bp_predict  in  2  predictor state used at fetch.
- id_pred_pc  in  XLEN  next-PC that IF fetched after this instruction.
- opA, opB  in  XLEN each  operands.
- du_stall  in  1  debug stall.
- du_flush  in  1  debug flush.
- du_we_pc  in  1  debug PC write strobe.
- du_dato  in  XLEN  debug PC data.
- bu_nxt_pc  out  XLEN  resolved next PC.
- bu_flush  out  1  redirect request.
- bu_cacheflush  out  1  FENCE.I flush.
- bu_misaligned  out  1  taken-target misalignment.
- bu_bp_predict  out  2  forwarded prediction.
- bu_bp_history  out  BP_GLOBAL_BITS  history excluding current branch.
- bu_bp_btaken  out  1  resolved direction.
- bu_bp_update  out  1  predictor update strobe.
- ras_top  out  XLEN  top-of-stack return address.
- ras_valid  out  1  stack non-empty.

Function
REQ-003 An instruction SHALL be valid when !id_bubble and !st_flush and !du_stall; registered outputs SHALL update one cycle after a valid instruction, and only when !ex_stall.
REQ-004 An instruction SHALL be treated as RVC when HAS_RVC=1 and id_instr[1:0]!=2'b11; the fall-through/link address SHALL be id_pc+2 for RVC and id_pc+4 otherwise.
REQ-005 Conditional branches SHALL resolve as follows:
- BEQ/BNE/BLT/BGE/BLTU/BGEU use signed or unsigned compare as named.
- nxt_pc = taken ? id_pc+immB : fall-through.
- update=1.
- flush = taken XOR id_bp_predict[1].
REQ-006 JAL SHALL set taken=1, update=0, flush=0 and nxt_pc=id_pc+immJ.
REQ-007 JALR SHALL set taken=1, update=0, nxt_pc=(opA+opB) with bit0 cleared, and flush=(nxt_pc!=id_pred_pc).
REQ-008 FENCE.I SHALL set flush=1, cacheflush=1 and nxt_pc=fall-through; all other instructions SHALL set flush=0 and nxt_pc=fall-through.
REQ-009 bu_misaligned SHALL be set when taken and (HAS_RVC ? nxt_pc[0] : |nxt_pc[1:0]), and SHALL be 0 otherwise.
REQ-010 A link register is x1 or x5. RAS operations for valid JAL/JALR SHALL be:
- rd is link and rs1 is not link: push.
- rs1 is link and rd is not link: pop.
- both link, rs1!=rd: pop then push, replacing the top entry.
- both link, rs1==rd: push.
The pushed value SHALL be the link address.
REQ-011 RAS push when full SHALL wrap the pointer and overwrite the oldest entry, with the count saturating at RAS_DEPTH; pop when empty SHALL be ignored, with the count staying 0.
REQ-012 ras_valid SHALL equal (count!=0), and ras_top SHALL be the entry at the top pointer; both SHALL be registered.
REQ-013 When bp update=1, the global history SHALL shift in btaken; bu_bp_history SHALL equal history[BP_GLOBAL_BITS:1].
REQ-014 bu_flush SHALL be pipeflush & ~du_stall & ~du_flush.
REQ-015 Debug PC override SHALL behave as follows:
- du_we_pc captures du_dato.
- While a debug write is pending (du_we_pc, held while du_stall), outputs SHALL be: bu_nxt_pc = captured value; bu_flush = du_we_pc delayed one cycle; cacheflush, btaken and update = 0.
- The RAS SHALL not change during the override.
REQ-016 When ex_stall and a valid instruction occur together, the stall SHALL win: no RAS or history change.

Reset
REQ-017 rstn low SHALL set bu_flush=1, bu_nxt_pc=PC_INIT, all other outputs 0, history 0, RAS count and pointer 0; RAS entry contents SHALL not be reset.
REQ-018 Reset asserted mid-operation SHALL take effect immediately (asynchronously) and override ex_stall.

Structure
REQ-019 Opcode/func constants, FENCE_I and the link-register indices SHALL reside in pu_riscv_verilog_pkg.
REQ-020 The return address stack SHALL be a sub-module, pu_riscv_ras, parametrised by XLEN and RAS_DEPTH, with push, pop, push_data, top and valid ports.

Verification
REQ-021 BEQ with opA=opB=5, id_bp_predict=2'b00, id_pc='h100, immB=+16 -> next cycle bu_nxt_pc='h110, bu_flush=1, bu_bp_btaken=1, bu_bp_update=1.
REQ-022 RVC instruction (id_instr[1:0]=2'b01) at id_pc='h200, non-branch -> bu_nxt_pc='h202, bu_flush=0.
REQ-023 JAL x1 at 'h1000 (32-bit), then JALR x0,0(x1) with opA='h1004, opB=0, id_pred_pc='h1004 -> ras_top='h1004 with ras_valid=1 after the JAL; after the JALR, bu_flush=0 and ras_valid=0.
REQ-024 Nine pushes with RAS_DEPTH=8, link addresses 'h4..'h24 -> ras_top='h24; eight pops -> ras_valid=0; a ninth pop -> no change, no X.
REQ-025 JALR to target 'h1001 with HAS_RVC=0 -> bu_nxt_pc='h1000, bu_misaligned=0; BNE taken to 'h1002 with HAS_RVC=0 -> bu_misaligned=1.
REQ-026 du_we_pc=1 with du_dato='hABC0 while du_stall=1, then a branch presented -> bu_nxt_pc='hABC0, bu_flush pulses once, RAS and history unchanged.

Source files
------------

// File: rtl/pu_riscv_verilog_pkg.sv
// Purpose: shared RISC-V opcode, funct3 and register constants, plus the branch-unit decode helpers.
// Latency: none; this package holds constants, types and functions only.
// Backpressure: none.
package pu_riscv_verilog_pkg;

    // Major opcodes, instr[6:0], 32-bit encodings only
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // Conditional branch funct3 values
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    // FENCE.I is identified by the pair {funct3, opcode}
    localparam logic [9:0] FENCE_I = {3'b001, OPC_MISC_MEM};

    // Link registers used as return-address hints
    localparam logic [4:0] REG_X1 = 5'd1;
    localparam logic [4:0] REG_X5 = 5'd5;

    // Instruction class as seen by the branch unit
    typedef enum logic [2:0] {
        BR_NONE,
        BR_COND,
        BR_JAL,
        BR_JALR,
        BR_FENCEI
    } br_kind_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_X1) || (r == REG_X5);
    endfunction

endpackage

// File: rtl/pu_riscv_bru_if.sv
// Purpose: groups the decode-side inputs and resolved outputs of the branch unit.
// Latency: none; this interface holds wires only.
// Backpressure: ex_stall and du_stall are carried through to the unit unchanged.
interface pu_riscv_bru_if #(
    parameter int XLEN           = 64,
    parameter int ILEN           = 64,
    parameter int BP_GLOBAL_BITS = 2
);
    import pu_riscv_verilog_pkg::*;

    logic                      ex_stall;
    logic                      st_flush;
    logic                      id_bubble;
    logic [XLEN-1:0]           id_pc;
    logic [ILEN-1:0]           id_instr;
    logic [1:0]                id_bp_predict;
    logic [XLEN-1:0]           id_pred_pc;
    logic [XLEN-1:0]           opA;
    logic [XLEN-1:0]           opB;
    logic                      du_stall;
    logic                      du_flush;
    logic                      du_we_pc;
    logic [XLEN-1:0]           du_dato;
    logic [XLEN-1:0]           bu_nxt_pc;
    logic                      bu_flush;
    logic                      bu_cacheflush;
    logic                      bu_misaligned;
    logic [1:0]                bu_bp_predict;
    logic [BP_GLOBAL_BITS-1:0] bu_bp_history;
    logic                      bu_bp_btaken;
    logic                      bu_bp_update;
    logic [XLEN-1:0]           ras_top;
    logic                      ras_valid;

    // Pipeline/debug side: drives the instruction and observes the resolution
    modport master (
        output ex_stall, st_flush, id_bubble, id_pc, id_instr, id_bp_predict,
               id_pred_pc, opA, opB, du_stall, du_flush, du_we_pc, du_dato,
        input  bu_nxt_pc, bu_flush, bu_cacheflush, bu_misaligned, bu_bp_predict,
               bu_bp_history, bu_bp_btaken, bu_bp_update, ras_top, ras_valid
    );

    // Branch unit side
    modport slave (
        input  ex_stall, st_flush, id_bubble, id_pc, id_instr, id_bp_predict,
               id_pred_pc, opA, opB, du_stall, du_flush, du_we_pc, du_dato,
        output bu_nxt_pc, bu_flush, bu_cacheflush, bu_misaligned, bu_bp_predict,
               bu_bp_history, bu_bp_btaken, bu_bp_update, ras_top, ras_valid
    );

endinterface

// File: rtl/pu_riscv_ras.sv
// Purpose: circular return-address stack; a push when full overwrites the oldest entry, and a pop when empty is ignored.
// Latency: 1 cycle; top and valid are registered and reflect the operation of the previous cycle.
// Backpressure: none; the caller gates push/pop, and push+pop together replaces the top entry.
module pu_riscv_ras #(
    parameter int XLEN      = 64,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            valid
);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0] CNT_MAX = (PW+1)'(RAS_DEPTH);

    logic [XLEN-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]   r_ptr;
    logic [PW:0]     r_cnt;

    logic            w_empty;
    logic            w_replace;
    logic            w_do_push;
    logic            w_do_pop;
    logic [PW-1:0]   w_ptr_inc;
    logic [PW-1:0]   w_ptr_dec;
    logic [PW:0]     w_cnt_nxt;

    // The depth is a power of two, so the pointer wraps by natural overflow
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_ptr_dec = r_ptr - 1'b1;
    assign w_empty   = (r_cnt == '0);
    assign w_replace = push & pop & ~w_empty;
    assign w_do_push = push & ~w_replace;
    assign w_do_pop  = pop & ~push & ~w_empty;

    // Next occupancy: saturates at the depth on push and holds at zero on pop
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_do_push && (r_cnt != CNT_MAX))
            w_cnt_nxt = r_cnt + 1'b1;
        else if (w_do_pop)
            w_cnt_nxt = r_cnt - 1'b1;
    end

    // Entry storage, left without reset; only pointer and count are cleared
    always_ff @(posedge clk) begin
        if (w_replace)
            r_mem[r_ptr] <= push_data;
        else if (w_do_push)
            r_mem[w_ptr_inc] <= push_data;
    end

    // Pointer, count and registered view of the top entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
            r_cnt <= '0;
            top   <= '0;
            valid <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            valid <= (w_cnt_nxt != '0);
            if (w_replace) begin
                top <= push_data;
            end else if (w_do_push) begin
                r_ptr <= w_ptr_inc;
                top   <= push_data;
            end else if (w_do_pop) begin
                r_ptr <= w_ptr_dec;
                top   <= r_mem[w_ptr_dec];
            end
        end
    end

endmodule

// File: rtl/pu_riscv_bru.sv
// Purpose: resolves branches, jumps and FENCE.I, drives redirect and predictor update, and maintains the RAS and global history.
// Latency: 1 cycle from a valid instruction to the registered outputs.
// Backpressure: ex_stall freezes all state; du_stall invalidates the slot; a pending debug PC write overrides the outputs.
module pu_riscv_bru
    import pu_riscv_verilog_pkg::*;
#(
    parameter int              XLEN           = 64,
    parameter int              ILEN           = 64,
    parameter logic [XLEN-1:0] PC_INIT        = 'h8000_0000,
    parameter int              BP_GLOBAL_BITS = 2,
    parameter int              HAS_RVC        = 1,
    parameter int              RAS_DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      ex_stall,
    input  logic                      st_flush,
    input  logic                      id_bubble,
    input  logic [XLEN-1:0]           id_pc,
    input  logic [ILEN-1:0]           id_instr,
    input  logic [1:0]                id_bp_predict,
    input  logic [XLEN-1:0]           id_pred_pc,
    input  logic [XLEN-1:0]           opA,
    input  logic [XLEN-1:0]           opB,
    input  logic                      du_stall,
    input  logic                      du_flush,
    input  logic                      du_we_pc,
    input  logic [XLEN-1:0]           du_dato,
    output logic [XLEN-1:0]           bu_nxt_pc,
    output logic                      bu_flush,
    output logic                      bu_cacheflush,
    output logic                      bu_misaligned,
    output logic [1:0]                bu_bp_predict,
    output logic [BP_GLOBAL_BITS-1:0] bu_bp_history,
    output logic                      bu_bp_btaken,
    output logic                      bu_bp_update,
    output logic [XLEN-1:0]           ras_top,
    output logic                      ras_valid
);
    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic            w_valid;
    logic            w_is_rvc;
    logic [XLEN-1:0] w_fall;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_jalr_sum;
    br_kind_e        w_kind;
    logic            w_cmp;
    logic            w_taken;
    logic            w_update;
    logic            w_pipeflush;
    logic            w_cacheflush;
    logic [XLEN-1:0] w_nxt_pc;
    logic            w_misal;
    logic            w_dbg_ovr;
    logic [XLEN-1:0] w_dbg_pc;
    logic            w_rd_link;
    logic            w_rs1_link;
    logic            w_ras_ok;
    logic            w_ras_push;
    logic            w_ras_pop;
    logic            w_unused;

    logic [XLEN-1:0]         r_dbg_pc;
    logic                    r_we_dly;
    logic                    r_dbg_pend;
    logic [BP_GLOBAL_BITS:0] r_hist;

    assign w_opcode   = id_instr[6:0];
    assign w_f3       = id_instr[14:12];
    assign w_rd       = id_instr[11:7];
    assign w_rs1      = id_instr[19:15];
    assign w_valid    = ~id_bubble & ~st_flush & ~du_stall;
    assign w_is_rvc   = (HAS_RVC != 0) && (id_instr[1:0] != 2'b11);
    assign w_fall     = id_pc + (w_is_rvc ? XLEN'(2) : XLEN'(4));
    assign w_imm_b    = {{(XLEN-12){id_instr[31]}}, id_instr[7], id_instr[30:25],
                         id_instr[11:8], 1'b0};
    assign w_imm_j    = {{(XLEN-20){id_instr[31]}}, id_instr[19:12], id_instr[20],
                         id_instr[30:21], 1'b0};
    assign w_jalr_sum = opA + opB;
    // Only part of the instruction word is decoded here
    assign w_unused   = ^id_instr;

    // Classify the instruction; compressed encodings never match a 32-bit opcode
    always_comb begin
        w_kind = BR_NONE;
        case (w_opcode)
            OPC_BRANCH: if (w_f3 != 3'b010 && w_f3 != 3'b011) w_kind = BR_COND;
            OPC_JAL:    w_kind = BR_JAL;
            OPC_JALR:   if (w_f3 == F3_JALR) w_kind = BR_JALR;
            default:    if ({w_f3, w_opcode} == FENCE_I) w_kind = BR_FENCEI;
        endcase
    end

    // Branch condition evaluation
    always_comb begin
        w_cmp = 1'b0;
        case (w_f3)
            F3_BEQ:  w_cmp = (opA == opB);
            F3_BNE:  w_cmp = (opA != opB);
            F3_BLT:  w_cmp = ($signed(opA) <  $signed(opB));
            F3_BGE:  w_cmp = ($signed(opA) >= $signed(opB));
            F3_BLTU: w_cmp = (opA <  opB);
            F3_BGEU: w_cmp = (opA >= opB);
            default: w_cmp = 1'b0;
        endcase
    end

    // Resolve direction, target, redirect and predictor update
    always_comb begin
        w_taken      = 1'b0;
        w_update     = 1'b0;
        w_pipeflush  = 1'b0;
        w_cacheflush = 1'b0;
        w_nxt_pc     = w_fall;
        case (w_kind)
            BR_COND: begin
                w_taken     = w_cmp;
                w_update    = 1'b1;
                w_nxt_pc    = w_cmp ? (id_pc + w_imm_b) : w_fall;
                w_pipeflush = w_cmp ^ id_bp_predict[1];
            end
            BR_JAL: begin
                w_taken  = 1'b1;
                w_nxt_pc = id_pc + w_imm_j;
            end
            BR_JALR: begin
                w_taken     = 1'b1;
                w_nxt_pc    = {w_jalr_sum[XLEN-1:1], 1'b0};
                w_pipeflush = ({w_jalr_sum[XLEN-1:1], 1'b0} != id_pred_pc);
            end
            BR_FENCEI: begin
                w_pipeflush  = 1'b1;
                w_cacheflush = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_misal = w_taken & ((HAS_RVC != 0) ? w_nxt_pc[0] : |w_nxt_pc[1:0]);

    // Debug override is active on the write strobe and stays until du_stall drops
    assign w_dbg_ovr = du_we_pc | r_dbg_pend;
    assign w_dbg_pc  = du_we_pc ? du_dato : r_dbg_pc;

    // A JAL has no rs1 field, so only a JALR can pop
    assign w_rd_link  = is_link(w_rd);
    assign w_rs1_link = (w_kind == BR_JALR) && is_link(w_rs1);
    assign w_ras_ok   = w_valid & ~ex_stall & ~w_dbg_ovr &
                        ((w_kind == BR_JAL) || (w_kind == BR_JALR));
    assign w_ras_push = w_ras_ok & w_rd_link;
    assign w_ras_pop  = w_ras_ok & w_rs1_link & (~w_rd_link | (w_rs1 != w_rd));

    // Capture the debug PC and track the pending write and its one-cycle delay
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dbg_pc   <= '0;
            r_we_dly   <= 1'b0;
            r_dbg_pend <= 1'b0;
        end else begin
            r_we_dly <= du_we_pc;
            if (du_we_pc) begin
                r_dbg_pc   <= du_dato;
                r_dbg_pend <= 1'b1;
            end else if (!du_stall) begin
                r_dbg_pend <= 1'b0;
            end
        end
    end

    // Registered resolution outputs; the debug override takes priority over ex_stall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bu_nxt_pc     <= PC_INIT;
            bu_flush      <= 1'b1;
            bu_cacheflush <= 1'b0;
            bu_misaligned <= 1'b0;
            bu_bp_predict <= 2'b00;
            bu_bp_btaken  <= 1'b0;
            bu_bp_update  <= 1'b0;
        end else if (w_dbg_ovr) begin
            bu_nxt_pc     <= w_dbg_pc;
            bu_flush      <= r_we_dly;
            bu_cacheflush <= 1'b0;
            bu_misaligned <= 1'b0;
            bu_bp_btaken  <= 1'b0;
            bu_bp_update  <= 1'b0;
        end else if (!ex_stall) begin
            bu_flush      <= w_valid & w_pipeflush & ~du_stall & ~du_flush;
            bu_cacheflush <= w_valid & w_cacheflush;
            bu_misaligned <= w_valid & w_misal;
            bu_bp_predict <= w_valid ? id_bp_predict : 2'b00;
            bu_bp_btaken  <= w_valid & w_taken;
            bu_bp_update  <= w_valid & w_update;
            if (w_valid)
                bu_nxt_pc <= w_nxt_pc;
        end
    end

    // Global history; bit 0 holds the newest outcome, excluded from the published view
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_hist <= '0;
        else if (w_valid && !ex_stall && !w_dbg_ovr && w_update)
            r_hist <= {r_hist[BP_GLOBAL_BITS-1:0], w_taken};
    end

    assign bu_bp_history = r_hist[BP_GLOBAL_BITS:1];

    pu_riscv_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_ras_push),
        .pop       (w_ras_pop),
        .push_data (w_fall),
        .top       (ras_top),
        .valid     (ras_valid)
    );

endmodule

// File: tb/tb_pu_riscv_bru.sv
// Purpose: directed self-checking bench for pu_riscv_bru, covering the default build and a HAS_RVC=0 build.
// Latency: outputs are sampled 1 ns after the rising edge that follows each driven instruction.
// Backpressure: ex_stall, st_flush, du_stall and the debug PC write are each exercised directly.
module tb_pu_riscv_bru;
    import pu_riscv_verilog_pkg::*;

    localparam int          XLEN    = 64;
    localparam int          ILEN    = 64;
    localparam int          BPG     = 2;
    localparam logic [63:0] PC_INIT = 64'h8000_0000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pu_riscv_bru_if #(.XLEN(XLEN), .ILEN(ILEN), .BP_GLOBAL_BITS(BPG)) bif ();

    pu_riscv_bru #(.XLEN(XLEN), .ILEN(ILEN), .PC_INIT(PC_INIT), .BP_GLOBAL_BITS(BPG),
                   .HAS_RVC(1), .RAS_DEPTH(8)) dut (
        .clk(clk), .rstn(rstn), .ex_stall(bif.ex_stall), .st_flush(bif.st_flush),
        .id_bubble(bif.id_bubble), .id_pc(bif.id_pc), .id_instr(bif.id_instr),
        .id_bp_predict(bif.id_bp_predict), .id_pred_pc(bif.id_pred_pc),
        .opA(bif.opA), .opB(bif.opB), .du_stall(bif.du_stall), .du_flush(bif.du_flush),
        .du_we_pc(bif.du_we_pc), .du_dato(bif.du_dato), .bu_nxt_pc(bif.bu_nxt_pc),
        .bu_flush(bif.bu_flush), .bu_cacheflush(bif.bu_cacheflush),
        .bu_misaligned(bif.bu_misaligned), .bu_bp_predict(bif.bu_bp_predict),
        .bu_bp_history(bif.bu_bp_history), .bu_bp_btaken(bif.bu_bp_btaken),
        .bu_bp_update(bif.bu_bp_update), .ras_top(bif.ras_top), .ras_valid(bif.ras_valid)
    );

    // Second build without compressed-instruction support, fed the same inputs
    logic [XLEN-1:0] d2_nxt_pc, d2_ras_top;
    logic            d2_flush, d2_cacheflush, d2_misaligned, d2_btaken, d2_update, d2_ras_valid;
    logic [1:0]      d2_bp_predict;
    logic [BPG-1:0]  d2_bp_history;

    pu_riscv_bru #(.XLEN(XLEN), .ILEN(ILEN), .PC_INIT(PC_INIT), .BP_GLOBAL_BITS(BPG),
                   .HAS_RVC(0), .RAS_DEPTH(8)) dut_norvc (
        .clk(clk), .rstn(rstn), .ex_stall(bif.ex_stall), .st_flush(bif.st_flush),
        .id_bubble(bif.id_bubble), .id_pc(bif.id_pc), .id_instr(bif.id_instr),
        .id_bp_predict(bif.id_bp_predict), .id_pred_pc(bif.id_pred_pc),
        .opA(bif.opA), .opB(bif.opB), .du_stall(bif.du_stall), .du_flush(bif.du_flush),
        .du_we_pc(bif.du_we_pc), .du_dato(bif.du_dato), .bu_nxt_pc(d2_nxt_pc),
        .bu_flush(d2_flush), .bu_cacheflush(d2_cacheflush), .bu_misaligned(d2_misaligned),
        .bu_bp_predict(d2_bp_predict), .bu_bp_history(d2_bp_history),
        .bu_bp_btaken(d2_btaken), .bu_bp_update(d2_update), .ras_top(d2_ras_top),
        .ras_valid(d2_ras_valid)
    );

    function automatic logic [63:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [12:0] imm);
        return {32'h0, imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [63:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {32'h0, imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [63:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {32'h0, imm, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [63:0] pc, input logic [63:0] instr, input logic [63:0] a,
                         input logic [63:0] b, input logic [1:0] pred, input logic [63:0] ppc);
        bif.id_bubble     = 1'b0;
        bif.id_pc         = pc;
        bif.id_instr      = instr;
        bif.opA           = a;
        bif.opB           = b;
        bif.id_bp_predict = pred;
        bif.id_pred_pc    = ppc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bif.ex_stall = 0; bif.st_flush = 0; bif.id_bubble = 1; bif.id_pc = '0;
        bif.id_instr = '0; bif.id_bp_predict = '0; bif.id_pred_pc = '0;
        bif.opA = '0; bif.opB = '0; bif.du_stall = 0; bif.du_flush = 0;
        bif.du_we_pc = 0; bif.du_dato = '0;

        // Reset values
        step(); step();
        chk("rst_flush", bif.bu_flush, 1);
        chk("rst_nxt_pc", bif.bu_nxt_pc, PC_INIT);
        chk("rst_ras_valid", bif.ras_valid, 0);
        chk("rst_update", bif.bu_bp_update, 0);
        chk("rst_history", bif.bu_bp_history, 0);
        @(negedge clk) rstn = 1'b1;
        step();
        chk("idle_flush", bif.bu_flush, 0);
        chk("idle_nxt_pc", bif.bu_nxt_pc, PC_INIT);

        // BEQ taken, predicted not-taken
        drive(64'h100, enc_b(F3_BEQ, 1, 2, 13'd16), 5, 5, 2'b00, 0);
        step();
        chk("beq_nxt_pc", bif.bu_nxt_pc, 64'h110);
        chk("beq_flush", bif.bu_flush, 1);
        chk("beq_btaken", bif.bu_bp_btaken, 1);
        chk("beq_update", bif.bu_bp_update, 1);
        chk("beq_history", bif.bu_bp_history, 2'b00);

        // BLT signed taken backwards, predicted taken
        drive(64'h300, enc_b(F3_BLT, 1, 2, 13'h1FF8), 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'b11, 0);
        step();
        chk("blt_nxt_pc", bif.bu_nxt_pc, 64'h2F8);
        chk("blt_flush", bif.bu_flush, 0);
        chk("blt_history", bif.bu_bp_history, 2'b01);

        // BLTU on the same operands is not taken, predicted taken
        drive(64'h300, enc_b(F3_BLTU, 1, 2, 13'h1FF8), 64'hFFFF_FFFF_FFFF_FFFF, 1, 2'b11, 0);
        step();
        chk("bltu_nxt_pc", bif.bu_nxt_pc, 64'h304);
        chk("bltu_flush", bif.bu_flush, 1);
        chk("bltu_btaken", bif.bu_bp_btaken, 0);
        chk("bltu_predict", bif.bu_bp_predict, 2'b11);
        chk("bltu_history", bif.bu_bp_history, 2'b11);

        // Compressed non-branch
        drive(64'h200, 64'h0000_0001, 0, 0, 2'b00, 0);
        step();
        chk("rvc_nxt_pc", bif.bu_nxt_pc, 64'h202);
        chk("rvc_flush", bif.bu_flush, 0);
        chk("rvc_update", bif.bu_bp_update, 0);

        // FENCE.I
        drive(64'h400, 64'h0000_100F, 0, 0, 2'b00, 0);
        step();
        chk("fencei_nxt_pc", bif.bu_nxt_pc, 64'h404);
        chk("fencei_flush", bif.bu_flush, 1);
        chk("fencei_cacheflush", bif.bu_cacheflush, 1);

        // JAL x1 then return JALR x0,0(x1)
        drive(64'h1000, enc_j(REG_X1, 21'd8), 0, 0, 2'b00, 0);
        step();
        chk("jal_nxt_pc", bif.bu_nxt_pc, 64'h1008);
        chk("jal_flush", bif.bu_flush, 0);
        chk("jal_update", bif.bu_bp_update, 0);
        chk("jal_ras_top", bif.ras_top, 64'h1004);
        chk("jal_ras_valid", bif.ras_valid, 1);
        drive(64'h1008, enc_jalr(5'd0, REG_X1, 12'd0), 64'h1004, 0, 2'b00, 64'h1004);
        step();
        chk("ret_nxt_pc", bif.bu_nxt_pc, 64'h1004);
        chk("ret_flush", bif.bu_flush, 0);
        chk("ret_ras_valid", bif.ras_valid, 0);

        // JALR target differs from the fetched next-PC; bit 0 cleared
        drive(64'h1100, enc_jalr(5'd0, 5'd6, 12'd0), 64'h3000, 64'h11, 2'b00, 64'h2000);
        step();
        chk("jalr_mp_nxt_pc", bif.bu_nxt_pc, 64'h3010);
        chk("jalr_mp_flush", bif.bu_flush, 1);

        // ex_stall wins over a valid JAL x1
        bif.ex_stall = 1'b1;
        drive(64'h5000, enc_j(REG_X1, 21'd8), 0, 0, 2'b00, 0);
        step();
        chk("stall_nxt_pc", bif.bu_nxt_pc, 64'h3010);
        chk("stall_flush", bif.bu_flush, 1);
        chk("stall_ras_valid", bif.ras_valid, 0);
        bif.ex_stall = 1'b0;

        // st_flush squashes the instruction
        bif.st_flush = 1'b1;
        step();
        chk("sqflush_flush", bif.bu_flush, 0);
        chk("sqflush_ras_valid", bif.ras_valid, 0);
        bif.st_flush = 1'b0;

        // Nine pushes into an eight-entry stack
        for (int i = 0; i < 9; i++) begin
            drive(64'(i * 4), enc_j(REG_X1, 21'd4), 0, 0, 2'b00, 0);
            step();
        end
        chk("ras9_top", bif.ras_top, 64'h24);
        chk("ras9_valid", bif.ras_valid, 1);
        drive(64'h800, enc_jalr(5'd0, REG_X1, 12'd0), 0, 0, 2'b00, 0);
        step();
        chk("pop1_top", bif.ras_top, 64'h20);
        for (int i = 0; i < 7; i++) step();
        chk("pop8_valid", bif.ras_valid, 0);
        chk("pop8_top", bif.ras_top, 64'h24);
        step();
        chk("pop9_valid", bif.ras_valid, 0);
        chk("pop9_top", bif.ras_top, 64'h24);

        // Push, then JALR x1,0(x5) replaces the top, then pop to empty
        drive(64'h600, enc_j(REG_X1, 21'd8), 0, 0, 2'b00, 0);
        step();
        chk("push_top", bif.ras_top, 64'h604);
        drive(64'h700, enc_jalr(REG_X1, REG_X5, 12'd0), 64'h604, 0, 2'b00, 64'h604);
        step();
        chk("repl_top", bif.ras_top, 64'h704);
        chk("repl_valid", bif.ras_valid, 1);
        drive(64'h604, enc_jalr(5'd0, REG_X1, 12'd0), 64'h704, 0, 2'b00, 64'h704);
        step();
        chk("repl_pop_valid", bif.ras_valid, 0);

        // Alignment rules without compressed support
        drive(64'h900, enc_jalr(5'd0, 5'd6, 12'd0), 64'h1000, 1, 2'b00, 64'h1000);
        step();
        chk("norvc_jalr_nxt_pc", d2_nxt_pc, 64'h1000);
        chk("norvc_jalr_misal", d2_misaligned, 0);
        chk("norvc_jalr_flush", d2_flush, 0);
        drive(64'h1000, enc_b(F3_BNE, 1, 2, 13'd2), 1, 2, 2'b00, 0);
        step();
        chk("norvc_bne_nxt_pc", d2_nxt_pc, 64'h1002);
        chk("norvc_bne_misal", d2_misaligned, 1);
        chk("rvc_bne_misal", bif.bu_misaligned, 0);
        chk("bne_history", bif.bu_bp_history, 2'b10);

        // Debug PC write while debug-stalled, then a branch presented
        bif.id_bubble = 1'b1;
        bif.du_stall  = 1'b1;
        bif.du_we_pc  = 1'b1;
        bif.du_dato   = 64'hABC0;
        step();
        chk("dbg0_nxt_pc", bif.bu_nxt_pc, 64'hABC0);
        chk("dbg0_flush", bif.bu_flush, 0);
        bif.du_we_pc = 1'b0;
        drive(64'h100, enc_b(F3_BEQ, 1, 2, 13'd16), 5, 5, 2'b00, 0);
        step();
        chk("dbg1_nxt_pc", bif.bu_nxt_pc, 64'hABC0);
        chk("dbg1_flush", bif.bu_flush, 1);
        chk("dbg1_update", bif.bu_bp_update, 0);
        step();
        chk("dbg2_flush", bif.bu_flush, 0);
        chk("dbg2_nxt_pc", bif.bu_nxt_pc, 64'hABC0);
        bif.du_stall  = 1'b0;
        bif.id_bubble = 1'b1;
        step(); step();
        chk("dbg3_flush", bif.bu_flush, 0);
        chk("dbg3_nxt_pc", bif.bu_nxt_pc, 64'hABC0);
        chk("dbg3_history", bif.bu_bp_history, 2'b10);
        chk("dbg3_ras_valid", bif.ras_valid, 0);

        // Asynchronous reset mid-cycle overrides ex_stall
        bif.ex_stall = 1'b1;
        drive(64'h1000, enc_j(REG_X1, 21'd8), 0, 0, 2'b00, 0);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_flush", bif.bu_flush, 1);
        chk("arst_nxt_pc", bif.bu_nxt_pc, PC_INIT);
        chk("arst_history", bif.bu_bp_history, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
